// File: rtl/stopwatch_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_pkg
// Shared types and helpers for the stopwatch control block: the control-FSM
// state encoding, divider/half-period derivation from the clock frequencies,
// and counter-width helpers.
// Optional feature macro used by the block: STOPWATCH_LAP_EN (adds LAP state).
// -----------------------------------------------------------------------------
package stopwatch_pkg;

    // Control FSM states. LAP is only reachable when STOPWATCH_LAP_EN is set.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        LAP     = 2'd2,
        PAUSED  = 2'd3
    } sw_state_e;

    // Default clock frequencies (board clock, centisecond tick, 2 Hz blink).
    localparam int DEFAULT_BOARD_HZ = 100_000_000;
    localparam int DEFAULT_TICK_HZ  = 100;
    localparam int DEFAULT_BLINK_HZ = 2;

    // Board cycles per count tick.
    function automatic int calc_div(input int board_hz, input int tick_hz);
        return (tick_hz > 0) ? (board_hz / tick_hz) : 0;
    endfunction

    // Board cycles per half blink period (display toggles once per half).
    function automatic int calc_half(input int board_hz, input int blink_hz);
        return (blink_hz > 0) ? (board_hz / (2 * blink_hz)) : 0;
    endfunction

    // True when num/den is an exact integer of at least 2.
    function automatic bit ratio_ok(input int num, input int den);
        if (den <= 0) begin
            return 1'b0;
        end
        return ((num % den) == 0) && ((num / den) >= 2);
    endfunction

    // Bits needed to hold 0..n-1; never less than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage : stopwatch_pkg

// File: rtl/stopwatch_ctrl_tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
// Modulo-N counter with count enable, synchronous zero and a terminal pulse.
// wrap_o is combinational: it is high in the cycle whose clock edge takes the
// count from N-1 back to 0, so the parent can register it alongside its own
// state and keep every top-level output registered.
// Synchronous active-low reset.
// -----------------------------------------------------------------------------
module tick_gen
    import stopwatch_pkg::*;
#(
    parameter int N = 10,
    parameter int W = cnt_width(N)
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic zero_i,
    output logic wrap_o
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: zero wins over enable; wrap to 0 after the last value.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the block leaves it unassigned, which would infer a latch.
        cnt_d  = cnt_q;
        wrap_o = 1'b0;
        if (zero_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            if (cnt_q == LAST) begin
                cnt_d  = '0;
                wrap_o = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples values from before the edge, independent of block ordering.
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : tick_gen

// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
// Control FSM for the stopwatch. Converts single-cycle start/stop and
// lap/reset button pulses into registered run, tick, clear, lap_hold and
// display_blank controls, and owns the board-clock to tick division.
//
// Configuration macro: STOPWATCH_LAP_EN
//   defined   - LAP state present; lap_reset in RUNNING freezes the display.
//   undefined - no LAP state; lap_reset in RUNNING is ignored, lap_hold = 0.
//
// Reset is synchronous, active-low. All outputs are registered and reflect
// the state entered at the edge that sampled the button.
// -----------------------------------------------------------------------------
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int BOARD_CLOCK_FREQUENCY_IN_HZ = DEFAULT_BOARD_HZ,
    parameter int TICK_FREQUENCY_IN_HZ        = DEFAULT_TICK_HZ,
    parameter int BLINK_FREQUENCY_IN_HZ       = DEFAULT_BLINK_HZ
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_start_stop,
    input  logic btn_lap_reset,
    input  logic max_reached,
    output logic run,
    output logic tick,
    output logic clear,
    output logic lap_hold,
    output logic display_blank
);

    localparam int DIV    = calc_div(BOARD_CLOCK_FREQUENCY_IN_HZ, TICK_FREQUENCY_IN_HZ);
    localparam int HALF   = calc_half(BOARD_CLOCK_FREQUENCY_IN_HZ, BLINK_FREQUENCY_IN_HZ);
    localparam int DIV_W  = cnt_width(DIV);
    localparam int HALF_W = cnt_width(HALF);

    // Reject frequency combinations that do not divide into whole cycles.
    if (!ratio_ok(BOARD_CLOCK_FREQUENCY_IN_HZ, TICK_FREQUENCY_IN_HZ)) begin : g_bad_div
        $error("stopwatch_ctrl: BOARD/TICK must be an integer >= 2");
    end
    if (!ratio_ok(BOARD_CLOCK_FREQUENCY_IN_HZ, 2 * BLINK_FREQUENCY_IN_HZ)) begin : g_bad_half
        $error("stopwatch_ctrl: BOARD/(2*BLINK) must be an integer >= 2");
    end

    sw_state_e state_q;
    sw_state_e state_d;

    logic run_q,   run_d;
    logic tick_q,  tick_d;
    logic clear_q, clear_d;
    logic blank_q, blank_d;

    logic div_en;
    logic div_zero;
    logic div_wrap;
    logic blink_stay;
    logic blink_wrap;

    // Next-state decode. start_stop beats lap_reset when both arrive together;
    // max_reached beats both buttons while counting.
    always_comb begin
        state_d = state_q;
        clear_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (btn_start_stop) begin
                    state_d = RUNNING;
                end else if (btn_lap_reset) begin
                    clear_d = 1'b1;
                end
            end
            RUNNING: begin
                if (max_reached || btn_start_stop) begin
                    state_d = PAUSED;
                end else if (btn_lap_reset) begin
`ifdef STOPWATCH_LAP_EN
                    state_d = LAP;
`else
                    state_d = RUNNING;
`endif
                end
            end
`ifdef STOPWATCH_LAP_EN
            LAP: begin
                if (max_reached || btn_start_stop) begin
                    state_d = PAUSED;
                end else if (btn_lap_reset) begin
                    state_d = RUNNING;
                end
            end
`endif
            PAUSED: begin
                if (btn_start_stop) begin
                    // A resume at the terminal count would immediately
                    // overrun, so it is ignored until the counter is cleared.
                    if (!max_reached) begin
                        state_d = RUNNING;
                    end
                end else if (btn_lap_reset) begin
                    state_d = IDLE;
                    clear_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Tick divider enables: counts only in the counting states, held while
    // paused (sub-tick phase survives pause/resume), zeroed while idle.
    always_comb begin
        run_d    = (state_d == RUNNING) || (state_d == LAP);
        div_en   = run_d;
        div_zero = (state_q == IDLE);
        tick_d   = div_wrap;
    end

    tick_gen #(
        .N (DIV),
        .W (DIV_W)
    ) u_div (
        .clk    (clk),
        .rst    (rst),
        .en_i   (div_en),
        .zero_i (div_zero),
        .wrap_o (div_wrap)
    );

    // Blink half-period: runs only while remaining in PAUSED, so it restarts
    // from zero on every entry and the display is unblanked on exit.
    always_comb begin
        blink_stay = (state_q == PAUSED) && (state_d == PAUSED);
        blank_d    = blink_stay ? (blank_q ^ blink_wrap) : 1'b0;
    end

    tick_gen #(
        .N (HALF),
        .W (HALF_W)
    ) u_blink (
        .clk    (clk),
        .rst    (rst),
        .en_i   (blink_stay),
        .zero_i (!blink_stay),
        .wrap_o (blink_wrap)
    );

    // State and registered outputs; reset returns to IDLE without a clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            run_q   <= 1'b0;
            tick_q  <= 1'b0;
            clear_q <= 1'b0;
            blank_q <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            tick_q  <= tick_d;
            clear_q <= clear_d;
            blank_q <= blank_d;
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic lap_hold_q;
    logic lap_hold_d;

    // Display freeze follows the LAP state.
    always_comb begin
        lap_hold_d = (state_d == LAP);
    end

    // Registered lap_hold.
    always_ff @(posedge clk) begin
        if (!rst) begin
            lap_hold_q <= 1'b0;
        end else begin
            lap_hold_q <= lap_hold_d;
        end
    end

    assign lap_hold = lap_hold_q;
`else
    assign lap_hold = 1'b0;
`endif

    assign run           = run_q;
    assign tick          = tick_q;
    assign clear         = clear_q;
    assign display_blank = blank_q;

endmodule : stopwatch_ctrl

// File: tb/tb_stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_ctrl
// Directed bench for stopwatch_ctrl with BOARD=1000, TICK=100, BLINK=50,
// giving DIV=10 and HALF=10. Inputs change and outputs are sampled on the
// falling edge. Lap-specific expectations follow STOPWATCH_LAP_EN.
// -----------------------------------------------------------------------------
module tb_stopwatch_ctrl;

`ifdef STOPWATCH_LAP_EN
    localparam logic LAP_ON = 1'b1;
`else
    localparam logic LAP_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic btn_start_stop;
    logic btn_lap_reset;
    logic max_reached;
    logic run;
    logic tick;
    logic clear;
    logic lap_hold;
    logic display_blank;

    int n_checks = 0;
    int n_pass   = 0;

    stopwatch_ctrl #(
        .BOARD_CLOCK_FREQUENCY_IN_HZ (1000),
        .TICK_FREQUENCY_IN_HZ        (100),
        .BLINK_FREQUENCY_IN_HZ       (50)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .btn_start_stop (btn_start_stop),
        .btn_lap_reset  (btn_lap_reset),
        .max_reached    (max_reached),
        .run            (run),
        .tick           (tick),
        .clear          (clear),
        .lap_hold       (lap_hold),
        .display_blank  (display_blank)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Hold the given buttons for one sampling edge, return on the next falling
    // edge with the outputs that edge produced.
    task automatic pulse(input logic ss, input logic lr);
        btn_start_stop = ss;
        btn_lap_reset  = lr;
        @(negedge clk);
        btn_start_stop = 1'b0;
        btn_lap_reset  = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".run"},   {31'd0, run},           32'd0);
        check({tag, ".tick"},  {31'd0, tick},          32'd0);
        check({tag, ".clear"}, {31'd0, clear},         32'd0);
        check({tag, ".lap"},   {31'd0, lap_hold},      32'd0);
        check({tag, ".blank"}, {31'd0, display_blank}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst            = 1'b0;
        btn_start_stop = 1'b0;
        btn_lap_reset  = 1'b0;
        max_reached    = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("idle");

        // Start from IDLE: run next cycle, ticks 10/20/30 cycles later.
        pulse(1'b1, 1'b0);
        check("start.run",  {31'd0, run},  32'd1);
        check("start.tick", {31'd0, tick}, 32'd0);
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            check($sformatf("start.tick%0d", k), {31'd0, tick}, {31'd0, (k % 10) == 0});
        end

        // Pause 4 cycles after the tick just seen, hold 25 cycles.
        repeat (3) @(negedge clk);
        pulse(1'b1, 1'b0);
        check("pause.run",   {31'd0, run},           32'd0);
        check("pause.tick",  {31'd0, tick},          32'd0);
        check("pause.blank", {31'd0, display_blank}, 32'd0);
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            check($sformatf("pause.blank%0d", k), {31'd0, display_blank}, (k / 10) % 2);
            check($sformatf("pause.tick%0d", k),  {31'd0, tick},          32'd0);
        end

        // Resume: divider held at 3, so next tick 6 cycles after run.
        pulse(1'b1, 1'b0);
        check("resume.run",   {31'd0, run},           32'd1);
        check("resume.blank", {31'd0, display_blank}, 32'd0);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            check($sformatf("resume.tick%0d", k), {31'd0, tick}, {31'd0, k == 6});
        end

        // Lap: display freezes (with LAP), counting continues either way.
        pulse(1'b0, 1'b1);
        check("lap.hold",  {31'd0, lap_hold}, {31'd0, LAP_ON});
        check("lap.run",   {31'd0, run},      32'd1);
        check("lap.clear", {31'd0, clear},    32'd0);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            check($sformatf("lap.tick%0d", k), {31'd0, tick},     {31'd0, (k == 9) || (k == 19)});
            check($sformatf("lap.hold%0d", k), {31'd0, lap_hold}, {31'd0, LAP_ON});
        end
        pulse(1'b0, 1'b1);
        check("unlap.hold", {31'd0, lap_hold}, 32'd0);
        check("unlap.run",  {31'd0, run},      32'd1);

        // Reset path: pause, lap_reset -> clear + IDLE, then clear from IDLE.
        pulse(1'b1, 1'b0);
        check("rp.pause.run", {31'd0, run}, 32'd0);
        pulse(1'b0, 1'b1);
        check("rp.clear",  {31'd0, clear},         32'd1);
        check("rp.run",    {31'd0, run},           32'd0);
        check("rp.blank",  {31'd0, display_blank}, 32'd0);
        @(negedge clk);
        check("rp.clear_off", {31'd0, clear}, 32'd0);
        pulse(1'b0, 1'b1);
        check("idle.clear", {31'd0, clear}, 32'd1);
        check("idle.run",   {31'd0, run},   32'd0);
        @(negedge clk);
        check("idle.clear_off", {31'd0, clear}, 32'd0);

        // Simultaneous buttons in RUNNING: start_stop wins.
        pulse(1'b1, 1'b0);
        check("sim.start.run", {31'd0, run}, 32'd1);
        pulse(1'b1, 1'b1);
        check("sim.run",   {31'd0, run},      32'd0);
        check("sim.lap",   {31'd0, lap_hold}, 32'd0);
        check("sim.clear", {31'd0, clear},    32'd0);

        // Terminal count: max_reached pauses, and blocks resume.
        pulse(1'b1, 1'b0);
        check("max.resume.run", {31'd0, run}, 32'd1);
        max_reached = 1'b1;
        @(negedge clk);
        check("max.run",  {31'd0, run},  32'd0);
        check("max.tick", {31'd0, tick}, 32'd0);
        pulse(1'b1, 1'b0);
        check("max.ignored.run", {31'd0, run}, 32'd0);
        @(negedge clk);
        check("max.ignored.run2", {31'd0, run}, 32'd0);
        max_reached = 1'b0;

        // Reset mid-LAP, then a fresh start ticks after 10 cycles.
        pulse(1'b1, 1'b0);
        check("mid.run", {31'd0, run}, 32'd1);
        pulse(1'b0, 1'b1);
        check("mid.lap", {31'd0, lap_hold}, {31'd0, LAP_ON});
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check_all_zero("midrst");
        pulse(1'b1, 1'b0);
        check("restart.run", {31'd0, run}, 32'd1);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            check($sformatf("restart.tick%0d", k), {31'd0, tick}, {31'd0, k == 10});
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_stopwatch_ctrl

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Control FSM for the stopwatch: turns single-cycle start/stop and lap/reset button pulses into the run, tick, clear, lap-hold and pause-blink controls that drive the time counter and display. It sits between the button conditioning logic and the BCD time counter and display mux. It owns the board-clock-to-tick division, so the counter only ever sees one-cycle tick enables.

## Interface
- BOARD_CLOCK_FREQUENCY_IN_HZ, 100_000_000, input clock frequency
- TICK_FREQUENCY_IN_HZ, 100, count resolution (centiseconds)
- BLINK_FREQUENCY_IN_HZ, 2, display blink rate while paused
- clk  input  1  system clock; one clock domain
- rst  input  1  reset, synchronous, active-low
- btn_start_stop  input  1  one-cycle pulse, toggles run/pause
- btn_lap_reset  input  1  one-cycle pulse, lap or reset depending on state
- max_reached  input  1  level from time counter, count at terminal value
- run  output  1  high in RUNNING and LAP
- tick  output  1  one-cycle count enable at TICK_FREQUENCY_IN_HZ while running
- clear  output  1  one-cycle pulse, zero the time counter
- lap_hold  output  1  display freezes the latched value while high
- display_blank  output  1  blanks the display; toggles only in PAUSED

## Operation
- DIV = BOARD/TICK and HALF = BOARD/(2·BLINK). Both must be integers ≥2; any other value is an elaboration error.
- States: IDLE, RUNNING, LAP, PAUSED. Reset enters IDLE.
- IDLE:
  - start_stop → RUNNING; divider count is zeroed.
  - lap_reset → clear pulse, stay IDLE.
- RUNNING:
  - start_stop or max_reached → PAUSED.
  - lap_reset → LAP.
- LAP:
  - lap_reset → RUNNING.
  - start_stop or max_reached → PAUSED.
  - lap_hold is 1 only in LAP. Counting continues underneath.
- PAUSED:
  - start_stop → RUNNING if max_reached=0; ignored if max_reached=1.
  - lap_reset → IDLE with clear pulse.
- Simultaneous button pulses: start_stop wins and lap_reset is dropped. max_reached has priority over both in RUNNING and LAP.
- Divider:
  - counts 0..DIV-1 only in RUNNING/LAP.
  - tick=1 when count==DIV-1 in RUNNING/LAP, then wraps to 0.
  - holds its value in PAUSED, so sub-tick phase is preserved across pause/resume.
  - zeroed in IDLE.
- Blink:
  - a separate counter runs 0..HALF-1 in PAUSED only.
  - display_blank toggles at wrap.
  - on entry to PAUSED, counter=0 and display_blank=0; on exit, display_blank=0.
- Reset mid-operation aborts everything. No clear pulse is issued by reset; the time counter has its own reset.

## Timing
- Reset values: run=0, tick=0, clear=0, lap_hold=0, display_blank=0, state IDLE, both counters 0.
- All outputs are registered.
- Button pulse sampled at edge N → state and outputs updated at edge N+1.
- clear is high exactly one cycle, in the cycle after the sampled lap_reset.
- From IDLE start, the first tick is high DIV cycles after run first goes high. Ticks then repeat every DIV cycles.
- First display_blank toggle comes HALF cycles after entering PAUSED.
- tick is never high in the cycle in which run is 0.

## Configuration
- STOPWATCH_LAP_EN defined: LAP state and lap_hold behaviour as above.
- STOPWATCH_LAP_EN undefined:
  - LAP state removed; lap_hold tied 0.
  - lap_reset in RUNNING is ignored.
  - lap_reset in IDLE and PAUSED behaves unchanged.

## Structure
- Shared package stopwatch_pkg holds:
  - state enum (IDLE, RUNNING, LAP, PAUSED);
  - DIV/HALF derivation and width constants ($clog2 of each).
- One sub-module, tick_gen: a parameterised modulo-N counter with enable, synchronous zero and a terminal pulse. It is instantiated twice, once for the tick divider and once for the blink half-period.

## Test plan
Parameters for all scenarios: BOARD=1000, TICK=100 (DIV=10), BLINK=50 (HALF=10).
- Start from IDLE: pulse start_stop → run=1 next cycle; ticks 10, 20 and 30 cycles later; no other ticks.
- Pause/resume phase: pause 4 cycles after a tick, hold 25 cycles, resume → next tick 6 cycles after run=1; display_blank toggles every 10 cycles while paused and is 0 after resume.
- Lap (LAP_EN): lap_reset in RUNNING → lap_hold=1, ticks continue every 10 cycles; second lap_reset → lap_hold=0.
- Reset path: lap_reset in PAUSED → one-cycle clear, state IDLE, run=0; lap_reset in IDLE → another single clear.
- Simultaneous/terminal events:
  - both buttons in the same cycle in RUNNING → PAUSED, lap_hold stays 0;
  - max_reached=1 in RUNNING → PAUSED;
  - start_stop while max_reached=1 → stays PAUSED.
- rst=0 mid-LAP for one cycle → all outputs 0 next edge; next start produces its first tick 10 cycles after run.
